// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: request/result bundle for the bit-serial subtractor
//   master drives start, a, b, borrow_in; slave drives busy, done, diff,
//   borrow_out, diff_bit, diff_bit_valid
interface serial_subtractor_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             borrow_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             diff_bit;
    logic             diff_bit_valid;
    modport master (
        output start, a, b, borrow_in,
        input  busy, done, diff, borrow_out, diff_bit, diff_bit_valid
    );
    modport slave (
        input  start, a, b, borrow_in,
        output busy, done, diff, borrow_out, diff_bit, diff_bit_valid
    );
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: LSB-first bit-serial a - b - borrow_in with one full-subtractor cell
//   clk, rst (sync active-high), bus (slave): start/a/b/borrow_in in,
//   busy/done/diff/borrow_out/diff_bit/diff_bit_valid out
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input logic                clk,
    input logic                rst,
    serial_subtractor_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int CW = $clog2(WIDTH);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             w_q, w_d, bout_q, bout_d, bit_q, bit_d, vld_q, vld_d;
    logic             d, w_nx, last;
    always_comb begin
        d       = a_q[0] ^ b_q[0] ^ w_q;
        w_nx    = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & w_q);
        last    = cnt_q == CW'(WIDTH - 1);
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        w_d     = w_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        bit_d   = 1'b0;
        vld_d   = 1'b0;
        case (state_q)
            IDLE: if (bus.start) begin
                state_d = RUN;
                a_d     = bus.a;
                b_d     = bus.b;
                w_d     = bus.borrow_in;
                cnt_d   = '0;
            end
            RUN: begin
                // minuend register doubles as the difference accumulator
                a_d   = {d, a_q[WIDTH-1:1]};
                b_d   = b_q >> 1;
                w_d   = w_nx;
                cnt_d = cnt_q + 1'b1;
                bit_d = d;
                vld_d = 1'b1;
                if (last) begin
                    state_d = DONE;
                    diff_d  = {d, a_q[WIDTH-1:1]};
                    bout_d  = w_nx;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            w_q     <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            bit_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            w_q     <= w_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            bit_q   <= bit_d;
            vld_q   <= vld_d;
        end
    end
    assign bus.busy           = state_q == RUN;
    assign bus.done           = state_q == DONE;
    assign bus.diff           = diff_q;
    assign bus.borrow_out     = bout_q;
    assign bus.diff_bit       = bit_q;
    assign bus.diff_bit_valid = vld_q;
endmodule
